// File: rtl/codec_cfg_sequencer_pkg.sv
// Shared encodings for the WM8731 bring-up sequencer: FSM states, IIC_Avalon
// register map, control command and the codec's default I2C write address.
package cfg_pkg;

  typedef enum logic [2:0] {
    S_PWRUP   = 3'd0,
    S_IDLE    = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_REG  = 3'd3,
    S_WR_DEV  = 3'd4,
    S_WR_GO   = 3'd5,
    S_WAIT    = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_REG  = 2'd1;
  localparam logic [1:0] ADDR_DEV  = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam logic [7:0] CTRL_GO      = 8'h01;
  localparam logic [7:0] DEF_DEV_ADDR = 8'h34;

  // Busy covers the four write cycles and the inter-frame wait, never PWRUP.
  function automatic logic is_busy(input state_e s);
    return (s == S_WR_DATA) || (s == S_WR_REG) || (s == S_WR_DEV) ||
           (s == S_WR_GO)   || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// Write-only IIC_Avalon slave port: 2-bit register select, byte data, one-cycle strobe.
// No backpressure; the master relies on a fixed wait after each go command.
interface codec_cfg_sequencer_if;
  logic [1:0] Avalon_Address;
  logic [7:0] Avalon_Writedata;
  logic       Avalon_Write;

  modport master (output Avalon_Address, output Avalon_Writedata, output Avalon_Write);
  modport slave  (input  Avalon_Address, input  Avalon_Writedata, input  Avalon_Write);
endinterface

// File: rtl/codec_cfg_sequencer_rom.sv
// WM8731 register table, {reg[6:0], data[8:0]} per entry; purely combinational.
// Indices beyond the table return zero.
module wm8731_cfg_rom (
  input  logic [3:0]  index_i,
  output logic [15:0] entry_o
);

  always_comb begin
    entry_o = 16'h0000;
    case (index_i)
      4'd0: entry_o = 16'h001A;
      4'd1: entry_o = 16'h021A;
      4'd2: entry_o = 16'h047B;
      4'd3: entry_o = 16'h067B;
      4'd4: entry_o = 16'h08F8;
      4'd5: entry_o = 16'h0A06;
      4'd6: entry_o = 16'h0C00;
      4'd7: entry_o = 16'h0E01;
      4'd8: entry_o = 16'h1002;
      4'd9: entry_o = 16'h1201;
      default: entry_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Loads the WM8731 table through IIC_Avalon: per entry 4 back-to-back writes (data, reg,
// dev, go) then WAIT_CYCLES idle; outputs registered; Start ignored while busy.
module codec_cfg_sequencer
  import cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR     = DEF_DEV_ADDR,
  parameter int unsigned PWRUP_CYCLES = 1000000,
  parameter int unsigned WAIT_CYCLES  = 20000,
  parameter bit          AUTO_START   = 1'b1,
  parameter int unsigned NUM_ENTRIES  = 10
) (
  input  logic                  Clk_In,
  input  logic                  Reset,
  input  logic                  Start,
  codec_cfg_sequencer_if.master avl,
  output logic                  Cfg_Busy,
  output logic                  Cfg_Done,
  output logic [3:0]            Cfg_Index
);

  localparam int unsigned CNT_MAX = (PWRUP_CYCLES > WAIT_CYCLES) ? PWRUP_CYCLES : WAIT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX   = 4'(NUM_ENTRIES - 1);
  localparam state_e           RST_STATE  = AUTO_START ? S_PWRUP : S_IDLE;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       index_q, index_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             write_q, write_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      entry;

  // Looked up with the next index so the data byte is registered alongside its strobe.
  wm8731_cfg_rom u_rom (
    .index_i (index_d),
    .entry_o (entry)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = S_WR_DATA;
          cnt_d   = '0;
          index_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_WR_DATA;
          cnt_d   = '0;
          index_d = 4'd0;
        end
      end
      S_WR_DATA: state_d = S_WR_REG;
      S_WR_REG:  state_d = S_WR_DEV;
      S_WR_DEV:  state_d = S_WR_GO;
      S_WR_GO:   state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d = '0;
          if (index_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 4'd1;
            state_d = S_WR_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = ADDR_DATA;
    data_d  = 8'h00;
    write_d = 1'b0;
    busy_d  = is_busy(state_d);
    done_d  = (state_d == S_DONE);
    case (state_d)
      S_WR_DATA: begin write_d = 1'b1; addr_d = ADDR_DATA; data_d = entry[7:0];  end
      S_WR_REG:  begin write_d = 1'b1; addr_d = ADDR_REG;  data_d = entry[15:8]; end
      S_WR_DEV:  begin write_d = 1'b1; addr_d = ADDR_DEV;  data_d = DEV_ADDR;    end
      S_WR_GO:   begin write_d = 1'b1; addr_d = ADDR_CTRL; data_d = CTRL_GO;     end
      default:   ;
    endcase
  end

  always_ff @(posedge Clk_In or negedge Reset) begin
    if (!Reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      index_q <= 4'd0;
      addr_q  <= 2'd0;
      data_q  <= 8'h00;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign avl.Avalon_Address   = addr_q;
  assign avl.Avalon_Writedata = data_q;
  assign avl.Avalon_Write     = write_q;
  assign Cfg_Busy             = busy_q;
  assign Cfg_Done             = done_q;
  assign Cfg_Index            = index_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench: DUT A auto-starts after power-up, DUT B waits for Start.
module tb_codec_cfg_sequencer;

  logic Clk_In = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  logic [3:0] idx_a, idx_b;

  int checks = 0;
  int errors = 0;

  codec_cfg_sequencer_if avl_a ();
  codec_cfg_sequencer_if avl_b ();

  codec_cfg_sequencer #(.DEV_ADDR(8'h34), .PWRUP_CYCLES(8), .WAIT_CYCLES(5),
                        .AUTO_START(1'b1), .NUM_ENTRIES(10)) dut_a (
    .Clk_In(Clk_In), .Reset(rst_a), .Start(start_a), .avl(avl_a),
    .Cfg_Busy(busy_a), .Cfg_Done(done_a), .Cfg_Index(idx_a));

  codec_cfg_sequencer #(.DEV_ADDR(8'h34), .PWRUP_CYCLES(8), .WAIT_CYCLES(5),
                        .AUTO_START(1'b0), .NUM_ENTRIES(10)) dut_b (
    .Clk_In(Clk_In), .Reset(rst_b), .Start(start_b), .avl(avl_b),
    .Cfg_Busy(busy_b), .Cfg_Done(done_b), .Cfg_Index(idx_b));

  always #5 Clk_In = ~Clk_In;

  // Cycles since DUT A reset release; equals n after the n-th rising edge.
  int cyc_a = 0;
  always @(posedge Clk_In or negedge rst_a)
    if (!rst_a) cyc_a <= 0;
    else        cyc_a <= cyc_a + 1;

  // Strobe logs and burst-shape watch, sampled on the falling edge.
  int wr_cnt_a = 0, wr_cnt_b = 0, run_a = 0, run_b = 0, burst_errs = 0;
  logic [9:0] log_a [0:63];
  logic [9:0] log_b [0:63];

  always @(negedge Clk_In) begin
    if (!rst_a) begin
      run_a    <= 0;
      wr_cnt_a <= 0;
    end else if (avl_a.Avalon_Write) begin
      if (run_a >= 4 || int'(avl_a.Avalon_Address) != run_a) burst_errs <= burst_errs + 1;
      run_a <= run_a + 1;
      if (wr_cnt_a < 64) log_a[wr_cnt_a] <= {avl_a.Avalon_Address, avl_a.Avalon_Writedata};
      wr_cnt_a <= wr_cnt_a + 1;
    end else begin
      run_a <= 0;
    end
  end

  always @(negedge Clk_In) begin
    if (!rst_b) begin
      run_b    <= 0;
      wr_cnt_b <= 0;
    end else if (avl_b.Avalon_Write) begin
      if (run_b >= 4 || int'(avl_b.Avalon_Address) != run_b) burst_errs <= burst_errs + 1;
      run_b <= run_b + 1;
      if (wr_cnt_b < 64) log_b[wr_cnt_b] <= {avl_b.Avalon_Address, avl_b.Avalon_Writedata};
      wr_cnt_b <= wr_cnt_b + 1;
    end else begin
      run_b <= 0;
    end
  end

  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  task automatic test_reset();
    #20;
    checks++;
    if ({avl_a.Avalon_Write, avl_a.Avalon_Address, avl_a.Avalon_Writedata,
         busy_a, done_a, idx_a} !== 18'd0) begin
      errors++;
      $display("FAIL reset_a: wr=%b addr=%0d data=%h busy=%b done=%b idx=%0d, expected all 0",
               avl_a.Avalon_Write, avl_a.Avalon_Address, avl_a.Avalon_Writedata, busy_a, done_a, idx_a);
    end
    checks++;
    if ({avl_b.Avalon_Write, avl_b.Avalon_Address, avl_b.Avalon_Writedata,
         busy_b, done_b, idx_b} !== 18'd0) begin
      errors++;
      $display("FAIL reset_b: wr=%b busy=%b done=%b idx=%0d, expected all 0",
               avl_b.Avalon_Write, busy_b, done_b, idx_b);
    end
  endtask

  task automatic test_pwrup_first_entry();
    logic [7:0] exp_data [4];
    int n;
    exp_data[0] = 8'h1A; exp_data[1] = 8'h00; exp_data[2] = 8'h34; exp_data[3] = 8'h01;
    @(posedge Clk_In); #1;
    rst_a = 1'b1;
    n = 0;
    while (n < 50 && avl_a.Avalon_Write !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL pwrup_latency: first write after %0d cycles, expected 8", n);
    end
    checks++;
    if (busy_a !== 1'b1 || idx_a !== 4'd0) begin
      errors++;
      $display("FAIL entry0_status: busy=%b idx=%0d, expected 1 and 0", busy_a, idx_a);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (avl_a.Avalon_Write !== 1'b1 || avl_a.Avalon_Address !== 2'(k) ||
          avl_a.Avalon_Writedata !== exp_data[k]) begin
        errors++;
        $display("FAIL entry0_write%0d: wr=%b addr=%0d data=%h, expected 1 %0d %h",
                 k, avl_a.Avalon_Write, avl_a.Avalon_Address, avl_a.Avalon_Writedata, k, exp_data[k]);
      end
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (avl_a.Avalon_Write !== 1'b0 || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL entry0_wait%0d: wr=%b busy=%b, expected 0 1", k, avl_a.Avalon_Write, busy_a);
      end
      if (k < 4) tick();
    end
    tick();
    checks++;
    if (avl_a.Avalon_Write !== 1'b1 || avl_a.Avalon_Address !== 2'd0 ||
        avl_a.Avalon_Writedata !== 8'h1A || idx_a !== 4'd1) begin
      errors++;
      $display("FAIL entry1_start: wr=%b addr=%0d data=%h idx=%0d, expected 1 0 1a 1",
               avl_a.Avalon_Write, avl_a.Avalon_Address, avl_a.Avalon_Writedata, idx_a);
    end
  endtask

  task automatic test_full_run();
    int n = 0;
    logic prev_busy = 1'b0, prev_wr = 1'b1;
    while (n < 300 && done_a !== 1'b1) begin
      prev_busy = busy_a;
      prev_wr   = avl_a.Avalon_Write;
      tick();
      n++;
    end
    checks++;
    if (done_a !== 1'b1 || cyc_a !== 98) begin
      errors++;
      $display("FAIL done_time: done=%b at cycle %0d, expected 1 at 98", done_a, cyc_a);
    end
    checks++;
    if (prev_busy !== 1'b1 || prev_wr !== 1'b0) begin
      errors++;
      $display("FAIL done_after_wait: prev busy=%b wr=%b, expected 1 0", prev_busy, prev_wr);
    end
    checks++;
    if (idx_a !== 4'd9 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL done_status: idx=%0d busy=%b, expected 9 0", idx_a, busy_a);
    end
    checks++;
    if (wr_cnt_a !== 40) begin
      errors++;
      $display("FAIL strobe_count: %0d writes, expected 40", wr_cnt_a);
    end
    checks++;
    if (log_a[24] !== {2'd0, 8'h00} || log_a[25] !== {2'd1, 8'h0C}) begin
      errors++;
      $display("FAIL entry6: got %h %h, expected 000 10c", log_a[24], log_a[25]);
    end
    checks++;
    if (log_a[36] !== {2'd0, 8'h01} || log_a[37] !== {2'd1, 8'h12} || log_a[38] !== {2'd2, 8'h34}) begin
      errors++;
      $display("FAIL entry9: got %h %h %h, expected 001 112 234", log_a[36], log_a[37], log_a[38]);
    end
    repeat (3) tick();
    checks++;
    if (done_a !== 1'b1 || avl_a.Avalon_Write !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: done=%b wr=%b, expected 1 0", done_a, avl_a.Avalon_Write);
    end
  endtask

  task automatic test_manual_start();
    @(posedge Clk_In); #1;
    rst_b = 1'b1;
    repeat (100) tick();
    checks++;
    if (wr_cnt_b !== 0 || busy_b !== 1'b0 || done_b !== 1'b0 || avl_b.Avalon_Write !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: writes=%0d busy=%b done=%b, expected 0 0 0", wr_cnt_b, busy_b, done_b);
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checks++;
    if (avl_b.Avalon_Write !== 1'b1 || avl_b.Avalon_Address !== 2'd0 ||
        avl_b.Avalon_Writedata !== 8'h1A || idx_b !== 4'd0 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL start_first_write: wr=%b addr=%0d data=%h idx=%0d busy=%b, expected 1 0 1a 0 1",
               avl_b.Avalon_Write, avl_b.Avalon_Address, avl_b.Avalon_Writedata, idx_b, busy_b);
    end
  endtask

  task automatic test_start_ignored_and_restart();
    int n = 0;
    repeat (31) tick();
    checks++;
    if (avl_b.Avalon_Write !== 1'b0 || busy_b !== 1'b1 || idx_b !== 4'd3) begin
      errors++;
      $display("FAIL entry3_wait: wr=%b busy=%b idx=%0d, expected 0 1 3", avl_b.Avalon_Write, busy_b, idx_b);
    end
    start_b = 1'b1;
    repeat (2) tick();
    start_b = 1'b0;
    repeat (3) tick();
    checks++;
    if (avl_b.Avalon_Write !== 1'b1 || avl_b.Avalon_Address !== 2'd0 ||
        avl_b.Avalon_Writedata !== 8'hF8 || idx_b !== 4'd4) begin
      errors++;
      $display("FAIL busy_start_ignored: wr=%b addr=%0d data=%h idx=%0d, expected 1 0 f8 4",
               avl_b.Avalon_Write, avl_b.Avalon_Address, avl_b.Avalon_Writedata, idx_b);
    end
    while (n < 300 && done_b !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (done_b !== 1'b1 || idx_b !== 4'd9 || wr_cnt_b !== 40) begin
      errors++;
      $display("FAIL b_done: done=%b idx=%0d writes=%0d, expected 1 9 40", done_b, idx_b, wr_cnt_b);
    end
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checks++;
    if (done_b !== 1'b0 || busy_b !== 1'b1 || avl_b.Avalon_Write !== 1'b1 ||
        avl_b.Avalon_Address !== 2'd0 || avl_b.Avalon_Writedata !== 8'h1A || idx_b !== 4'd0) begin
      errors++;
      $display("FAIL done_restart: done=%b busy=%b wr=%b addr=%0d data=%h idx=%0d, expected 0 1 1 0 1a 0",
               done_b, busy_b, avl_b.Avalon_Write, avl_b.Avalon_Address, avl_b.Avalon_Writedata, idx_b);
    end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    while (n < 100 && cyc_a < 45) begin
      tick();
      n++;
    end
    checks++;
    if (avl_a.Avalon_Write !== 1'b1 || avl_a.Avalon_Address !== 2'd1 ||
        avl_a.Avalon_Writedata !== 8'h08 || idx_a !== 4'd4) begin
      errors++;
      $display("FAIL entry4_wr_reg: wr=%b addr=%0d data=%h idx=%0d, expected 1 1 08 4",
               avl_a.Avalon_Write, avl_a.Avalon_Address, avl_a.Avalon_Writedata, idx_a);
    end
    #1 rst_a = 1'b0;
    #1;
    checks++;
    if (avl_a.Avalon_Write !== 1'b0 || avl_a.Avalon_Address !== 2'd0 ||
        busy_a !== 1'b0 || idx_a !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: wr=%b addr=%0d busy=%b idx=%0d, expected 0 0 0 0",
               avl_a.Avalon_Write, avl_a.Avalon_Address, busy_a, idx_a);
    end
    repeat (2) tick();
    rst_a = 1'b1;
    n = 0;
    while (n < 50 && avl_a.Avalon_Write !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 8 || avl_a.Avalon_Address !== 2'd0 || avl_a.Avalon_Writedata !== 8'h1A) begin
      errors++;
      $display("FAIL rerun_after_reset: latency=%0d addr=%0d data=%h, expected 8 0 1a",
               n, avl_a.Avalon_Address, avl_a.Avalon_Writedata);
    end
    repeat (12) tick();
  endtask

  task automatic test_burst_shape();
    checks++;
    if (burst_errs !== 0) begin
      errors++;
      $display("FAIL burst_shape: %0d bad strobes (run >4 or address out of order), expected 0", burst_errs);
    end
  endtask

  initial begin
    test_reset();
    test_pwrup_first_entry();
    test_full_run();
    test_manual_start();
    test_start_ignored_and_restart();
    test_reset_midrun();
    test_burst_shape();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
- Drives the 2-bit-address Avalon write port of IIC_Avalon to load the WM8731 audio codec register table over I2C.
- Walks a fixed table of 10 register writes.
- For each entry it writes data, register and device bytes, issues the go command, then waits a fixed time before the next entry.
- Replaces the hand-stepped bring-up logic and sits between top-level reset/start and the I2C master.

Parameters:
- DEV_ADDR, 8'h34, WM8731 write address written to IIC_Avalon address 2.
- PWRUP_CYCLES, 1000000, Clk_In cycles from reset release before auto-start (20 ms at 50 MHz).
- WAIT_CYCLES, 20000, Clk_In cycles waited after each go write (covers one 3-byte I2C frame plus margin).
- AUTO_START, 1, 1 = run the table once after power-up; 0 = wait for Start.
- NUM_ENTRIES, 10, table length (max 16).

Ports:
- Clk_In  input  1  system clock, 50 MHz.
- Reset  input  1  reset; asynchronous assert, active-low. Reset=0 clears all state.
- Start  input  1  level, sampled each cycle. 1 in IDLE or DONE (re)runs the table.
- Avalon_Address  output  2  IIC_Avalon register select.
- Avalon_Writedata  output  8  IIC_Avalon write data.
- Avalon_Write  output  1  one-cycle write strobe.
- Cfg_Busy  output  1  table in progress (PWRUP excluded).
- Cfg_Done  output  1  all entries issued; held until the next run or reset.
- Cfg_Index  output  4  entry currently issued; drives LEDR debug.

Behaviour:
- Reset values: Avalon_Address=0, Avalon_Writedata=0, Avalon_Write=0, Cfg_Busy=0, Cfg_Done=0, Cfg_Index=0. State = PWRUP if AUTO_START, else IDLE. Counter = 0.
- IIC_Avalon map:
  - addr0 = data byte (entry[7:0]).
  - addr1 = register byte (entry[15:8] = {reg[6:0], data[8]}).
  - addr2 = device address.
  - addr3 = control; writing 8'h01 starts the frame.
- States and transitions:
  - PWRUP: count to PWRUP_CYCLES-1, then go to WR_DATA with index 0 and counter cleared.
  - IDLE: if Start=1, go to WR_DATA with index 0 and Cfg_Done cleared.
  - WR_DATA: Write=1, addr0, entry low byte. Next state WR_REG.
  - WR_REG: Write=1, addr1, entry high byte. Next state WR_DEV.
  - WR_DEV: Write=1, addr2, DEV_ADDR. Next state WR_GO.
  - WR_GO: Write=1, addr3, 8'h01. Next state WAIT.
  - WAIT: Write=0. Count to WAIT_CYCLES-1.
    - If index==NUM_ENTRIES-1, go to DONE.
    - Otherwise increment index and go to WR_DATA.
  - DONE: Cfg_Done=1, Cfg_Busy=0. If Start=1, behave as IDLE+Start.
- Outputs are registered. Each write state lasts exactly 1 cycle, so Avalon_Write is high for 4 consecutive cycles per entry with addresses 0,1,2,3 in order.
- Per-entry period = 4 + WAIT_CYCLES cycles. Full run = NUM_ENTRIES*(4+WAIT_CYCLES) cycles.
- Cfg_Busy=1 in WR_* and WAIT.
- Start while busy or in PWRUP is ignored; there is no restart mid-table.
- Reset asserted mid-run:
  - Avalon_Write drops immediately (asynchronous).
  - After release, the sequencer restarts from PWRUP/IDLE; the table is re-run from entry 0.
  - A partially issued frame on the bus is IIC_Avalon's responsibility.
- Counter width: clog2 of max(PWRUP_CYCLES, WAIT_CYCLES). It is never compared beyond its terminal value and wraps to 0 on every state exit.
- Table contents, index 0..9 (16-bit {regbyte, databyte}): 001A, 021A, 047B, 067B, 08F8, 0A06, 0C00, 0E01, 1002, 1201.

Decomposition:
- Shared package cfg_pkg holds:
  - state encoding;
  - IIC_Avalon address constants (ADDR_DATA=0, ADDR_REG=1, ADDR_DEV=2, ADDR_CTRL=3);
  - CTRL_GO=8'h01;
  - default DEV_ADDR.
- Sub-module wm8731_cfg_rom: combinational 4-bit index to 16-bit entry. Out-of-range indices return 16'h0000.

Test Plan:
1. PWRUP_CYCLES=8, WAIT_CYCLES=5, AUTO_START=1; release Reset -> Avalon_Write first high 8 cycles after release. Addr/data sequence is (0,1A),(1,00),(2,34),(3,01), then 5 idle cycles.
2. Same bench, full run -> 40 write strobes total. Entry 6 emits (0,00),(1,0C). Cfg_Done rises 1 cycle after the final WAIT, with Cfg_Index=9. Cfg_Busy falls with it.
3. AUTO_START=0; hold Start=0 for 100 cycles -> no writes, Cfg_Busy=0. Pulse Start -> first write next cycle, Cfg_Index=0.
4. Start=1 during entry 3 WAIT -> ignored, sequence unchanged. Start=1 in DONE -> Cfg_Done clears and the table restarts at entry 0.
5. Assert Reset during the WR_REG cycle of entry 4 -> Avalon_Write=0 with no clock edge needed. After release, the first write after PWRUP is (0,1A).
6. Check with an assertion throughout: Avalon_Write is never high for more than 4 consecutive cycles, and Avalon_Address increments 0→3 within each burst.
